// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared definitions for the triangle-sweep sequencer and its counter datapath.
package updown_sweep_ctrl_pkg;

  localparam int unsigned DEF_WIDTH   = 3;
  localparam int unsigned DEF_SWEEP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_up_down_counter.sv
// Loadable up/down counter; load takes priority over a step.
module up_down_counter
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step_en) begin
      count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer driving an up/down counter through a programmed number of lo->hi->lo sweeps.
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               hold,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               dir_up,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweeps_done
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [SWEEP_W-1:0] n_q;
  logic [SWEEP_W-1:0] sd_next, sd_inc;
  logic               latch_cfg, cfg_err_next;
  logic               ctr_load, ctr_step, ctr_up;

  assign sd_inc = sweeps_done + SWEEP_W'(1);

  up_down_counter #(.WIDTH(WIDTH)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (lo_q),
    .step_en  (ctr_step),
    .up       (ctr_up),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= '0;
      sweeps_done <= '0;
      dir_up      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_next;
      sweeps_done <= sd_next;
      if (latch_cfg) begin
        lo_q <= lo;
        hi_q <= hi;
        n_q  <= n_sweeps;
      end
      // Outputs are registered from the next state so they line up with it.
      dir_up  <= (state_next == ST_UP);
      busy    <= (state_next == ST_LOAD) || (state_next == ST_UP) ||
                 (state_next == ST_DOWN);
      done    <= (state_next == ST_DONE);
      cfg_err <= cfg_err_next;
    end
  end

  always_comb begin
    state_next   = state;
    sd_next      = sweeps_done;
    latch_cfg    = 1'b0;
    cfg_err_next = 1'b0;
    ctr_load     = 1'b0;
    ctr_step     = 1'b0;
    ctr_up       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          if ((lo >= hi) || (n_sweeps == '0)) begin
            cfg_err_next = 1'b1;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (!hold) begin
          ctr_load   = 1'b1;
          sd_next    = '0;
          state_next = ST_UP;
        end
      end
      ST_UP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (!hold) begin
          ctr_step = 1'b1;
          if (count == hi_q) begin
            state_next = ST_DOWN;
          end else begin
            ctr_up = 1'b1;
          end
        end
      end
      ST_DOWN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (!hold) begin
          if (count == lo_q) begin
            sd_next = sd_inc;
            if (sd_inc == n_q) begin
              state_next = ST_DONE;
            end else begin
              ctr_step   = 1'b1;
              ctr_up     = 1'b1;
              state_next = ST_UP;
            end
          end else begin
            ctr_step = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with hand-computed expectations.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, hold;
  logic [2:0] lo, hi;
  logic [3:0] n_sweeps;
  logic [2:0] count;
  logic       dir_up, busy, done, cfg_err;
  logic [3:0] sweeps_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  updown_sweep_ctrl #(.WIDTH(3), .SWEEP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .hold        (hold),
    .lo          (lo),
    .hi          (hi),
    .n_sweeps    (n_sweeps),
    .count       (count),
    .dir_up      (dir_up),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .sweeps_done (sweeps_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt[13] = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
    int exp_dir[13] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    lo = '0; hi = '0; n_sweeps = '0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_dir", 32'(dir_up), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_sweeps", 32'(sweeps_done), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic run lo=2 hi=5 n=2, with an ignored mid-run start that changes hi
    lo = 3'd2; hi = 3'd5; n_sweeps = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", 32'(busy), 1);
    chk("load_dir", 32'(dir_up), 0);
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("run1_count[%0d]", i), 32'(count), 32'(exp_cnt[i]));
      chk($sformatf("run1_dir[%0d]", i), 32'(dir_up), 32'(exp_dir[i]));
      chk($sformatf("run1_busy[%0d]", i), 32'(busy), 1);
      chk($sformatf("run1_done[%0d]", i), 32'(done), 0);
      if (i == 1) begin
        start = 1'b1; hi = 3'd7;
      end else begin
        start = 1'b0;
      end
    end
    step();
    chk("run1_done", 32'(done), 1);
    chk("run1_done_count", 32'(count), 2);
    chk("run1_done_sweeps", 32'(sweeps_done), 2);
    chk("run1_done_busy", 32'(busy), 0);
    step();
    chk("run1_done_pulse", 32'(done), 0);
    chk("run1_idle_count", 32'(count), 2);

    // Config errors: lo==hi, then n==0
    lo = 3'd4; hi = 3'd4; n_sweeps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg1_err", 32'(cfg_err), 1);
    chk("cfg1_busy", 32'(busy), 0);
    chk("cfg1_count", 32'(count), 2);
    step();
    chk("cfg1_pulse", 32'(cfg_err), 0);
    chk("cfg1_busy2", 32'(busy), 0);
    lo = 3'd1; hi = 3'd6; n_sweeps = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg2_err", 32'(cfg_err), 1);
    chk("cfg2_busy", 32'(busy), 0);
    step();
    chk("cfg2_pulse", 32'(cfg_err), 0);
    chk("cfg2_count", 32'(count), 2);

    // Hold at count=4 in UP, then abort with hold at count=3 in DOWN
    lo = 3'd2; hi = 3'd5; n_sweeps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); chk("hold_pre0", 32'(count), 2);
    step(); chk("hold_pre1", 32'(count), 3);
    step(); chk("hold_pre2", 32'(count), 4);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_count[%0d]", i), 32'(count), 4);
      chk($sformatf("hold_busy[%0d]", i), 32'(busy), 1);
      chk($sformatf("hold_dir[%0d]", i), 32'(dir_up), 1);
      chk($sformatf("hold_sweeps[%0d]", i), 32'(sweeps_done), 0);
    end
    hold = 1'b0;
    step(); chk("hold_resume", 32'(count), 5);
    step(); chk("down_4", 32'(count), 4);
    chk("down_4_dir", 32'(dir_up), 0);
    step(); chk("down_3", 32'(count), 3);
    abort = 1'b1; hold = 1'b1;
    step();
    abort = 1'b0; hold = 1'b0;
    chk("abort_count", 32'(count), 3);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_dir", 32'(dir_up), 0);
    step();
    chk("abort_idle_count", 32'(count), 3);
    chk("abort_idle_done", 32'(done), 0);
    chk("abort_idle_busy", 32'(busy), 0);

    // Full range lo=0 hi=7 n=1: no wrap at either end
    lo = 3'd0; hi = 3'd7; n_sweeps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("full_load_busy", 32'(busy), 1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("full_count[%0d]", i), 32'(count), 32'((i <= 7) ? i : 14 - i));
      chk($sformatf("full_dir[%0d]", i), 32'(dir_up), 32'((i <= 7) ? 1 : 0));
    end
    step();
    chk("full_done", 32'(done), 1);
    chk("full_done_count", 32'(count), 0);
    chk("full_done_sweeps", 32'(sweeps_done), 1);
    step();
    chk("full_done_pulse", 32'(done), 0);

    // Async reset mid-sweep, between clock edges
    lo = 3'd1; hi = 3'd6; n_sweeps = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); chk("ar_pre0", 32'(count), 1);
    step(); chk("ar_pre1", 32'(count), 2);
    step(); chk("ar_pre2", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_dir", 32'(dir_up), 0);
    chk("ar_sweeps", 32'(sweeps_done), 0);
    step();
    chk("ar_hold_count", 32'(count), 0);
    rst_n = 1'b1;
    step();
    chk("ar_after_done", 32'(done), 0);
    chk("ar_after_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer that drives an up/down counter datapath through a programmed triangle sweep.
- Each sweep counts from lo up to hi and back down to lo; the pattern repeats for a programmed number of sweeps.
- Provides a start/done handshake, a hold (pause) control, an abort and config-error flagging.
- Sits between control logic and the up/down counter; replaces hand-driven dir_up/clear sequencing.

Parameters:
- WIDTH, 3, counter width in bits (count range 0..2^WIDTH-1).
- SWEEP_W, 4, width of the sweep-count configuration and status fields.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  terminate the current sequence.
- hold  input  1  freeze count and state while high.
- lo  input  WIDTH  sweep floor, latched on start.
- hi  input  WIDTH  sweep ceiling, latched on start.
- n_sweeps  input  SWEEP_W  number of full up+down sweeps, latched on start.
- count  output  WIDTH  current counter value (registered).
- dir_up  output  1  1 while in UP, else 0 (registered).
- busy  output  1  high from LOAD through the last DOWN cycle.
- done  output  1  one-cycle pulse on completion.
- cfg_err  output  1  one-cycle pulse when start is given with a bad config.
- sweeps_done  output  SWEEP_W  completed sweeps in the current run.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - count, dir_up, busy, done, cfg_err and sweeps_done are all 0.
- States: IDLE, LOAD, UP, DOWN, DONE. All outputs are registered.
- IDLE:
  - On start=1, latch lo, hi and n_sweeps.
  - If lo>=hi or n_sweeps==0: cfg_err=1 for one cycle and stay in IDLE.
  - Otherwise go to LOAD.
  - count holds its last value while in IDLE.
- LOAD (1 cycle):
  - count<=lo, sweeps_done<=0, busy=1, then go to UP.
- UP (dir_up=1):
  - If count!=hi: count<=count+1.
  - If count==hi: count<=hi-1 and go to DOWN. The peak is therefore shown for exactly one cycle.
- DOWN (dir_up=0):
  - If count!=lo: count<=count-1.
  - If count==lo: sweeps_done<=sweeps_done+1, then:
    - if sweeps_done+1==n_sweeps, go to DONE with count held at lo;
    - otherwise count<=lo+1 and go to UP.
- DONE (1 cycle):
  - done=1, busy=0, then return to IDLE.
- Latency: start at edge k gives count=lo at edge k+1. Each cycle after that takes one step.
- hold=1 (UP/DOWN/LOAD only):
  - count, state and sweeps_done are frozen; busy stays 1.
  - hold has no effect in IDLE or DONE.
- abort=1:
  - In any busy state: next state is IDLE, count is held, busy=0, and done is not pulsed.
  - abort has priority over hold and over state transitions.
  - abort in IDLE is ignored.
- start while busy or in DONE is ignored. Latched config does not change mid-run.
- Arithmetic never wraps: the lo<hi check guarantees count stays in [lo,hi].
- Asserting rst_n mid-run forces the reset values immediately; no done pulse is produced.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, UP, DOWN, DONE);
  - default WIDTH/SWEEP_W constants.
- One natural sub-module: up_down_counter, the count datapath. It has load, step-enable and direction inputs.
- The FSM, config latches and sweep counter stay in updown_sweep_ctrl.

Test Plan:
- Basic run: lo=2, hi=5, n=2, start pulse. Required count sequence from LOAD: 2,3,4,5,4,3,2,3,4,5,4,3,2, then done=1 for one cycle with count=2 and sweeps_done=2. dir_up=1 exactly on the cycles in UP (count rising toward 5 and the peak cycle itself).
- Full range, no wrap: lo=0, hi=7, n=1. Required sequence 0..7 then 6..0, then done; count never shows 0 after 7 or 7 after 0.
- Config errors: lo=4, hi=4 (and separately n=0) with start. Required: cfg_err pulses once, busy stays 0, count unchanged.
- Hold: assert hold for 3 cycles while count=4 in UP. Required: count stays 4 and busy=1 for 3 cycles, then resumes with 5.
- Abort: abort at count=3 in DOWN with hold also high. Required: IDLE next cycle, count=3, busy=0, no done pulse. A subsequent start must run normally.
- Async reset: pull rst_n low mid-sweep between clock edges. Required: count=0, busy=0, dir_up=0 immediately. A start ignored while busy must not relatch config: changing hi mid-run has no effect on the peak.
